// File: rtl/cv32e40s_prefetch_queue_pkg.sv
// Shared types and helpers for the OBI instruction prefetch queue.
package cv32e40s_prefetch_queue_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } prefetch_entry_t;

  localparam logic [31:0] WORD_INCR = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cv32e40s_prefetch_fifo.sv
// Response FIFO with wrap-around pointers; the head is read straight from storage.
module cv32e40s_prefetch_fifo
  import cv32e40s_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = prefetch_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output entry_t        head
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  entry_t      mem_r [DEPTH];
  logic        do_pop_s;

  assign do_pop_s = pop & ~empty;
  assign count    = wptr_r - rptr_r;
  assign empty    = (wptr_r == rptr_r);
  assign full     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign head     = mem_r[rptr_r[AW-1:0]];

  // Pointer update; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else if (flush) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cv32e40s_prefetch_queue_checker.sv
// Protocol and overflow properties of the prefetch queue.
module cv32e40s_prefetch_queue_checker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned OW              = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          resp_valid,
  input logic [OW-1:0] outstanding,
  input logic          push,
  input logic          pop,
  input logic          fifo_full
);

  a_resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && fifo_full) |-> pop);

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= OW'(MAX_OUTSTANDING));

endmodule

// File: rtl/cv32e40s_prefetch_queue.sv
// Instruction prefetcher: credit-limited OBI issue, flush-by-count discard and a response FIFO.
module cv32e40s_prefetch_queue
  import cv32e40s_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   branch_i,
  input  logic [31:0]                            branch_addr_i,
  input  logic                                   fetch_enable_i,
  output logic                                   trans_valid_o,
  input  logic                                   trans_ready_i,
  output logic [31:0]                            trans_addr_o,
  input  logic                                   resp_valid_i,
  input  logic [31:0]                            resp_rdata_i,
  input  logic                                   resp_err_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [31:0]                            out_rdata_o,
  output logic [31:0]                            out_addr_o,
  output logic                                   out_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = ((OW > AW + 1) ? OW : AW + 1) + 1;
  localparam logic [OW-1:0] CNT_ONE = OW'(1);

  logic [31:0]     fetch_ptr_r;
  logic [31:0]     resp_addr_r;
  logic [OW-1:0]   outstanding_r;
  logic [OW-1:0]   discard_r;
  logic [31:0]     branch_target_s;
  logic [OW-1:0]   live_s;
  logic [AW:0]     fifo_count_s;
  logic [AW:0]     fifo_eff_s;
  logic [SW-1:0]   credit_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  prefetch_entry_t push_entry_s;
  prefetch_entry_t head_s;

  assign branch_target_s = word_align(branch_addr_i);
  assign issue_s         = trans_valid_o & trans_ready_i;
  assign push_s          = resp_valid_i & ~branch_i & (discard_r == '0);
  assign pop_s           = out_valid_o & out_ready_i;
  assign push_entry_s    = '{rdata: resp_rdata_i, addr: resp_addr_r, err: resp_err_i};

  // Issue credit: flushed requests still hold a bus slot but no FIFO slot
  always_comb begin
    live_s   = outstanding_r - discard_r;
    fifo_eff_s = branch_i ? '0 : fifo_count_s;
    credit_s = SW'(live_s) + SW'(fifo_eff_s);
    trans_valid_o = fetch_enable_i && (outstanding_r < OW'(MAX_OUTSTANDING))
                    && (credit_s < SW'(DEPTH));
    if (branch_i) begin
      trans_addr_o = branch_target_s;
    end else begin
      trans_addr_o = fetch_ptr_r;
    end
  end

  // Head presentation; fields read as zero while the FIFO is empty
  always_comb begin
    out_valid_o = ~fifo_empty_s;
    if (out_valid_o) begin
      out_rdata_o = head_s.rdata;
      out_addr_o  = head_s.addr;
      out_err_o   = head_s.err;
    end else begin
      out_rdata_o = 32'h0000_0000;
      out_addr_o  = 32'h0000_0000;
      out_err_o   = 1'b0;
    end
  end

  assign outstanding_o = outstanding_r;
  assign busy_o        = (outstanding_r != '0);

  // Fetch and response address pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr_r <= 32'h0000_0000;
      resp_addr_r <= 32'h0000_0000;
    end else begin
      if (issue_s) begin
        fetch_ptr_r <= trans_addr_o + WORD_INCR;
      end else if (branch_i) begin
        fetch_ptr_r <= branch_target_s;
      end
      if (branch_i) begin
        resp_addr_r <= branch_target_s;
      end else if (push_s) begin
        resp_addr_r <= resp_addr_r + WORD_INCR;
      end
    end
  end

  // In-flight and discard accounting; a response in the branch cycle is already gone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      case ({issue_s, resp_valid_i})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
      if (branch_i) begin
        discard_r <= resp_valid_i ? (outstanding_r - CNT_ONE) : outstanding_r;
      end else if (resp_valid_i && (discard_r != '0)) begin
        discard_r <= discard_r - CNT_ONE;
      end
    end
  end

  cv32e40s_prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (prefetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (branch_i),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .head      (head_s)
  );

  cv32e40s_prefetch_queue_checker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OW              (OW)
  ) u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .resp_valid  (resp_valid_i),
    .outstanding (outstanding_r),
    .push        (push_s),
    .pop         (pop_s),
    .fifo_full   (fifo_full_s)
  );

endmodule

// File: doc/cv32e40s_prefetch_queue.md
Name: cv32e40s_prefetch_queue

Overview:
Parametrised next-generation instruction prefetcher for the 32-bit OBI instruction path.
- Issues word-aligned fetch transactions with up to MAX_OUTSTANDING requests in flight.
- Buffers responses in a DEPTH-entry FIFO.
- Handles branch flushes, discarding responses to flushed requests by count.
- Sits between the controller/alignment buffer (consumer side) and the OBI instruction interface (trans/resp side).

Parameters:
DEPTH, 4, response FIFO entries (power of two, 2..16)
MAX_OUTSTANDING, 2, maximum issued-but-unanswered transactions (1..DEPTH)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
branch_i  input  1  flush and redirect fetch (one-cycle pulse)
branch_addr_i  input  32  redirect target; bits[1:0] ignored
fetch_enable_i  input  1  permits new transaction issue
trans_valid_o  output  1  transaction request
trans_ready_i  input  1  transaction accepted
trans_addr_o  output  32  word-aligned request address
resp_valid_i  input  1  response beat
resp_rdata_i  input  32  response data
resp_err_i  input  1  bus error for this beat
out_valid_o  output  1  FIFO head valid
out_ready_i  input  1  consumer takes head
out_rdata_o  output  32  head data
out_addr_o  output  32  head word address
out_err_o  output  1  head error flag
outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  in-flight count, including flushed
busy_o  output  1  outstanding_o != 0

Behaviour:
Clock and reset:
- One clock domain, clk.
- rst_n is asynchronous and active-low.

Reset values:
- trans_valid_o=0, trans_addr_o=0, out_valid_o=0, out_rdata_o=0, out_addr_o=0, out_err_o=0, outstanding_o=0, busy_o=0.
- Internal fetch pointer = 0, discard count = 0, FIFO empty.

Issue rule (combinational):
- trans_valid_o = fetch_enable_i & (outstanding < MAX_OUTSTANDING) & (live_outstanding + fifo_count < DEPTH), where live_outstanding = outstanding − discard count.
- When branch_i=1: fifo_count is taken as 0 and trans_addr_o = {branch_addr_i[31:2],2'b00}. Otherwise trans_addr_o = fetch pointer.
- Issued when trans_valid_o & trans_ready_i.
- On issue, the fetch pointer ← trans_addr_o + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
- On a branch with no issue, the fetch pointer ← aligned branch_addr_i.
- trans_addr_o holds stable while trans_valid_o=1 and trans_ready_i=0, unless branch_i asserts (OBI address change on redirect is permitted).

Address tracking:
- A separate response address register starts at the branch/reset address.
- It increments by 4 on each non-discarded response written to the FIFO.
- The written entry carries that address.

Outstanding counter:
- +1 on issue, −1 on resp_valid_i.
- Both in the same cycle: unchanged.
- Never exceeds MAX_OUTSTANDING; resp_valid_i with outstanding=0 is illegal (assertion).

Flush on branch_i:
- FIFO is emptied at the clock edge; out_valid_o=0 in the next cycle.
- Discard count ← outstanding − (resp_valid_i ? 1 : 0). A transaction issued in the branch cycle is live and is not discarded.
- A response arriving in the branch cycle is dropped.

Discard:
- While discard count > 0, resp_valid_i decrements it and the beat is not written.
- A new branch reloads the discard count per the flush rule.

FIFO:
- Write on an accepted, non-discarded response.
- Read on out_valid_o & out_ready_i.
- Simultaneous read and write when full is legal; occupancy is unchanged.
- Overflow cannot occur by construction of the credit rule (assertion).
- Output is the registered FIFO head; zero added latency: data written at edge N is visible after edge N.

Errors:
- resp_err_i is stored with the entry.
- Issue continues; the controller decides whether to branch.

fetch_enable_i=0:
- Stops issue only; responses still drain.

busy_o:
- Equals outstanding_o != 0.

Reset mid-operation:
- All state clears asynchronously.
- Responses to pre-reset requests are the system's responsibility (bus is reset together).

Decomposition:
- Package: typedef prefetch_entry_t {rdata[31:0], addr[31:0], err}.
- Sub-module cv32e40s_prefetch_fifo:
  - Parametrised by DEPTH and the entry type.
  - Ports: push, pop, flush, count, head.
  - Wrap-around read/write pointers with an extra MSB for full/empty.
- Top level holds the issue logic, fetch pointer, response address register, outstanding counter and discard counter.

Test Plan:
1. Reset release, fetch_enable_i=1, branch to 0x100, trans_ready_i=1, one-cycle responses:
   - trans_addr_o sequence 0x100, 0x104, 0x108, …
   - out_addr_o matches, with out_rdata_o in order.
2. DEPTH=4, out_ready_i=0, responses immediate:
   - Exactly 4 issues, then trans_valid_o=0.
   - One pop → exactly one further issue.
3. MAX_OUTSTANDING=2, responses withheld:
   - Two issues, then trans_valid_o=0, outstanding_o=2.
   - Then branch to 0x200 with a response in the same cycle: discard count=1.
   - Next response dropped; first visible out_addr_o=0x200.
4. Branch to 0x202:
   - trans_addr_o=0x200 in the branch cycle; FIFO empty next cycle.
5. Fetch pointer at 0xFFFFFFF8, continuous issue:
   - Addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. Response with resp_err_i=1 at 0x104:
   - Entry out_err_o=1, out_addr_o=0x104.
   - Neighbouring entries have err=0; issue continues.
